// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes (same encoding as the
// ALU control decoder), FSM state encoding and the default datapath width.
package alu_exec_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_LUI  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_MUL    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative shift-add multiplier, one partial product per cycle over DATA_WIDTH cycles.
// done_o marks the final iteration; product_o is the value the accumulator takes on that edge.
module alu_mult_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] acc_d;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_o = acc_d;
  assign done_o    = (count_q == CW'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      count_q  <= CW'(DATA_WIDTH);
    end else if (count_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with start/busy/done handshake, 1-bit/cycle shifter and, when
// ALU_EXEC_MULT_EN is defined, a 32-cycle shift-add multiplier on code 1000.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            ALUOperation,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [4:0]            shamt,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] shreg_q, result_q;
  logic                  zero_q;
  logic [4:0]            count_q;

  logic                  accept, shift_req, mul_req;
  logic [DATA_WIDTH-1:0] single_res, shreg_step;

  // FINISH counts as idle so a request can issue back-to-back with a completion.
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
  assign shift_req = is_shift(ALUOperation) && (shamt != 5'd0);

`ifdef ALU_EXEC_MULT_EN
  logic                  mult_done;
  logic [DATA_WIDTH-1:0] mult_product;

  assign mul_req = (ALUOperation == OP_MULT);

  alu_mult_seq #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .clk_i     (clk),
    .rst_n_i   (reset),
    .start_i   (accept && mul_req),
    .a_i       (A),
    .b_i       (B),
    .done_o    (mult_done),
    .product_o (mult_product)
  );
`else
  assign mul_req = 1'b0;
`endif

  always_comb begin
    single_res = '0;
    case (ALUOperation)
      OP_AND:         single_res = A & B;
      OP_OR:          single_res = A | B;
      OP_NOR:         single_res = ~(A | B);
      OP_ADD:         single_res = A + B;
      OP_SUB:         single_res = A - B;
      OP_SLL, OP_SRL: single_res = B;
      OP_LUI:         single_res = {B[15:0], {(DATA_WIDTH-16){1'b0}}};
      default:        single_res = '0;
    endcase
  end

  assign shreg_step = (op_q == OP_SRL) ? (shreg_q >> 1) : (shreg_q << 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (!start)         state_d = ST_IDLE;
        else if (shift_req) state_d = ST_SHIFT;
        else if (mul_req)   state_d = ST_MUL;
        else                state_d = ST_FINISH;
      end
      ST_SHIFT: if (count_q == 5'd1) state_d = ST_FINISH;
`ifdef ALU_EXEC_MULT_EN
      ST_MUL:   if (mult_done) state_d = ST_FINISH;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFT) || (state_q == ST_MUL);
    done = (state_q == ST_FINISH);
  end

  // Result/Zero are written only on the edge that enters FINISH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_AND;
      shreg_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (accept) begin
      op_q <= ALUOperation;
      if (shift_req) begin
        shreg_q <= B;
        count_q <= shamt;
      end else if (!mul_req) begin
        result_q <= single_res;
        zero_q   <= (single_res == '0);
      end
    end else if (state_q == ST_SHIFT) begin
      shreg_q <= shreg_step;
      count_q <= count_q - 5'd1;
      if (count_q == 5'd1) begin
        result_q <= shreg_step;
        zero_q   <= (shreg_step == '0);
      end
    end
`ifdef ALU_EXEC_MULT_EN
    else if ((state_q == ST_MUL) && mult_done) begin
      result_q <= mult_product;
      zero_q   <= (mult_product == '0);
    end
`endif
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit: a cycle-level reference model tracks
// when each accepted request must complete and with what value, plus directed literal cases.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  sh = '0;
  logic [31:0] ALUResult;
  logic        Zero, busy, done;

  int checks = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .ALUOperation (op),
    .A            (a),
    .B            (b),
    .shamt        (sh),
    .ALUResult    (ALUResult),
    .Zero         (Zero),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [4:0] s);
    case (o)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return ~(x | y);
      4'd3: return x + y;
      4'd4: return x - y;
      4'd5: return y << s;
      4'd6: return y >> s;
      4'd7: return y << 16;
      4'd8: return MULT_EN ? x * y : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] o, input logic [4:0] s);
    if (o == 4'd5 || o == 4'd6) return int'(s);
    if (o == 4'd8 && MULT_EN) return 32;
    return 0;
  endfunction

  // Reference model: one outstanding request, its completion cycle and value.
  int          cyc = 0;
  bit          pending = 1'b0;
  int          exp_done = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  = 1'b0;
      last_res = '0;
    end else begin
      if (pending && cyc == exp_done) begin
        last_res = exp_res;
        pending  = 1'b0;
      end
      if (start && !(pending && cyc < exp_done)) begin
        exp_res  = model_result(op, a, b, sh);
        exp_done = cyc + 1 + model_latency(op, sh);
        pending  = 1'b1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic        e_done, e_busy;
      logic [31:0] e_res;
      e_done = pending && (cyc == exp_done);
      e_busy = pending && (cyc < exp_done);
      e_res  = e_done ? exp_res : last_res;
      chk("cyc_done", done, e_done);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_result", ALUResult, e_res);
      chk("cyc_zero", Zero, e_res == 32'd0);
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
  endtask

  task automatic issue(input string name, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s,
                       input logic [31:0] want, input int want_lat);
    int lat;
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y; sh = s;
    @(posedge clk); #2;
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; sh = 5'($urandom);
    wait_done(lat);
    chk({name, "_latency"}, lat, want_lat);
    chk({name, "_result"}, ALUResult, want);
    chk({name, "_zero"}, Zero, want == 32'd0);
    $display("txn %s op=%0d result=%h latency=%0d", name, o, ALUResult, lat);
  endtask

  initial begin
    int lat1, lat2, seen;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_result", ALUResult, 32'd0);
    chk("reset_zero", Zero, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst_n = 1'b1;

    issue("sub_eq", 4'd4, 32'd5, 32'd5, 5'd0, 32'h0000_0000, 1);
    issue("nor_zero", 4'd2, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1);
    issue("op_1001", 4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'h0000_0000, 1);
    issue("add", 4'd3, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h0000_0001, 1);
    issue("sll_31", 4'd5, 32'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 32);
    issue("srl_4", 4'd6, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 5);
    issue("sll_0", 4'd5, 32'd0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1);
    issue("lui", 4'd7, 32'd0, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1);
    issue("mult", 4'd8, 32'h0001_0000, 32'h0001_0001, 5'd0,
          MULT_EN ? 32'h0001_0000 : 32'h0, MULT_EN ? 33 : 1);

    // start held high across an SRL by 3: the second request issues in the FINISH cycle
    @(posedge clk); #2;
    start = 1'b1; op = 4'd6; b = 32'h0000_0080; sh = 5'd3;
    @(posedge clk); #2;
    b = 32'h0000_0100;
    wait_done(lat1);
    chk("hold_first_latency", lat1, 4);
    chk("hold_first_result", ALUResult, 32'h0000_0010);
    @(posedge clk); #2;
    start = 1'b0; b = 32'hDEAD_BEEF; sh = 5'd9;
    wait_done(lat2);
    chk("hold_second_latency", lat1 + lat2, 8);
    chk("hold_second_result", ALUResult, 32'h0000_0020);
    $display("txn hold_srl first_lat=%0d second_done_at=N+%0d result=%h", lat1, lat1 + lat2, ALUResult);

    // reset asserted in cycle N+5 of a 20-step shift
    @(posedge clk); #2;
    start = 1'b1; op = 4'd5; b = 32'h0000_0001; sh = 5'd20;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", ALUResult, 32'd0);
    chk("abort_zero", Zero, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    $display("txn reset_mid_sll done_pulses_after_abort=%0d", seen);

    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      op    = 4'($urandom_range(0, 10));
      a     = $urandom;
      b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      sh    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
